// File: rtl/mc_datapath_core_if.sv
// Control, memory/IO bus and status signals between a multi-cycle controller
// and the mc_datapath_core datapath.
interface mc_datapath_core_if;
    logic        MIO_ready;
    logic        IorD;
    logic        IRWrite;
    logic        RegWrite;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        Beq;
    logic        data2Mem;
    logic [1:0]  RegDst;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  PCSource;
    logic [1:0]  MemtoReg;
    logic [3:0]  ALU_operation;
    logic [31:0] data2CPU;
    logic [31:0] PC_Current;
    logic [31:0] Inst_R;
    logic [31:0] data_out;
    logic [31:0] M_addr;
    logic        zero;
    logic        overflow;

    modport master (
        output MIO_ready, IorD, IRWrite, RegWrite, PCWrite, PCWriteCond, Beq, data2Mem,
        output RegDst, ALUSrcA, ALUSrcB, PCSource, MemtoReg, ALU_operation, data2CPU,
        input  PC_Current, Inst_R, data_out, M_addr, zero, overflow
    );

    modport slave (
        input  MIO_ready, IorD, IRWrite, RegWrite, PCWrite, PCWriteCond, Beq, data2Mem,
        input  RegDst, ALUSrcA, ALUSrcB, PCSource, MemtoReg, ALU_operation, data2CPU,
        output PC_Current, Inst_R, data_out, M_addr, zero, overflow
    );
endinterface

// File: rtl/mc_datapath_core.sv
// Multi-cycle MIPS-style datapath: PC, IR, MDR, 32x32 register file, ALU and
// pipeline-free holding registers, steered entirely by an external controller.
module mc_datapath_core (
    input  logic                clk,
    input  logic                reset,
    mc_datapath_core_if.slave   bus
);
    logic [31:0] regs [32];
    logic [31:0] pc, ir, mdr, alu_out, alu_out2, data_to_cpu;
    logic [4:0]  rs, rt, rd, shamt, wr_addr;
    logic [15:0] imm;
    logic [31:0] sext, off, reg_a, reg_b, wr_data, src_a, src_b, result;
    logic        zero_flag, ovf, pc_en;

    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign imm   = ir[15:0];
    assign sext  = {{16{imm[15]}}, imm};
    assign off   = {sext[29:0], 2'b00};

    assign reg_a = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign reg_b = (rt == 5'd0) ? 32'd0 : regs[rt];

    always_comb begin
        wr_addr = rt;
        wr_data = alu_out;
        src_a   = reg_a;
        src_b   = reg_b;
        case (bus.RegDst)
            2'b00:   wr_addr = rt;
            2'b01:   wr_addr = rd;
            2'b10:   wr_addr = 5'd31;
            default: wr_addr = 5'd0;
        endcase
        case (bus.MemtoReg)
            2'b00:   wr_data = alu_out;
            2'b01:   wr_data = mdr;
            2'b10:   wr_data = {imm, 16'h0000};
            default: wr_data = pc;
        endcase
        case (bus.ALUSrcA)
            2'b00:   src_a = reg_a;
            2'b01:   src_a = pc;
            2'b10:   src_a = data_to_cpu;
            default: src_a = 32'h0;
        endcase
        case (bus.ALUSrcB)
            2'b00:   src_b = reg_b;
            2'b01:   src_b = 32'd4;
            2'b10:   src_b = sext;
            default: src_b = off;
        endcase
    end

    // Overflow is only meaningful for the signed add/subtract opcodes.
    always_comb begin
        result = 32'h0;
        ovf    = 1'b0;
        case (bus.ALU_operation)
            4'b0000: result = src_a & src_b;
            4'b0001: result = src_a | src_b;
            4'b0010: begin
                result = src_a + src_b;
                ovf    = (src_a[31] == src_b[31]) && (result[31] != src_a[31]);
            end
            4'b0011: result = src_a ^ src_b;
            4'b0100: result = ~(src_a | src_b);
            4'b0101: result = src_b >> shamt;
            4'b0110: begin
                result = src_a - src_b;
                ovf    = (src_a[31] != src_b[31]) && (result[31] != src_a[31]);
            end
            4'b0111: result = {31'd0, ($signed(src_a) < $signed(src_b))};
            4'b1000: result = src_b << shamt;
            4'b1001: result = $unsigned($signed(src_b) >>> shamt);
            4'b1010: result = {31'd0, (src_a < src_b)};
            default: result = 32'h0;
        endcase
    end

    assign zero_flag = (result == 32'h0);
    assign pc_en     = bus.PCWrite | (bus.PCWriteCond & (zero_flag == bus.Beq));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
            pc          <= 32'h0;
            ir          <= 32'h0;
            mdr         <= 32'h0;
            alu_out     <= 32'h0;
            alu_out2    <= 32'h0;
            data_to_cpu <= 32'h0;
        end else begin
            alu_out     <= result;
            alu_out2    <= alu_out;
            data_to_cpu <= bus.data2CPU;
            if (bus.MIO_ready) mdr <= bus.data2CPU;
            if (bus.IRWrite && bus.MIO_ready) ir <= bus.data2CPU;
            if (bus.RegWrite && (wr_addr != 5'd0)) regs[wr_addr] <= wr_data;
            // Sequential fetch only advances once the memory has delivered the word.
            if (pc_en) begin
                case (bus.PCSource)
                    2'b00:   if (bus.MIO_ready) pc <= result;
                    2'b10:   pc <= {pc[31:28], ir[25:0], 2'b00};
                    default: pc <= alu_out;
                endcase
            end
        end
    end

    assign bus.PC_Current = pc;
    assign bus.Inst_R     = ir;
    assign bus.zero       = zero_flag;
    assign bus.overflow   = ovf;
    assign bus.M_addr     = bus.IorD ? pc : alu_out;
    assign bus.data_out   = bus.data2Mem ? alu_out2 : reg_b;
endmodule

// File: tb/tb_mc_datapath_core.sv
// Scoreboarded bench for mc_datapath_core: directed fetch/addi/branch/overflow/
// jump/reset sequences followed by random control words against a reference model.
module tb_mc_datapath_core;
    typedef struct packed {
        logic        mio, iord, irw, rw, pcw, pcwc, beq, d2m;
        logic [1:0]  regdst, srca, srcb, pcsrc, m2r;
        logic [3:0]  op;
        logic [31:0] din;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc, ir, maddr, dout;
        logic        z, v;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    ctrl_t       cur;
    logic [31:0] m_pc, m_ir, m_mdr, m_aout, m_aout2, m_dtc;
    logic [31:0] m_regs [32];

    mc_datapath_core_if bus();

    mc_datapath_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU written from the opcode table with wide signed arithmetic.
    function automatic void alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] sh, output logic [31:0] r, output logic v);
        longint sa, sb, s;
        sa = $signed(a);
        sb = $signed(b);
        r = 32'h0;
        v = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin s = sa + sb; r = s[31:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd3:  r = a ^ b;
            4'd4:  r = ~(a | b);
            4'd5:  r = b >> sh;
            4'd6:  begin s = sa - sb; r = s[31:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  r = b << sh;
            4'd9:  begin r = b >> sh; if (b[31]) r = r | ~(32'hFFFF_FFFF >> sh); end
            4'd10: r = (a < b) ? 32'd1 : 32'd0;
            default: r = 32'h0;
        endcase
    endfunction

    function automatic void model_eval(output logic [31:0] r, output logic v);
        logic [31:0] a, b, sx;
        sx = {{16{m_ir[15]}}, m_ir[15:0]};
        case (cur.srca)
            2'd0: a = m_regs[m_ir[25:21]];
            2'd1: a = m_pc;
            2'd2: a = m_dtc;
            default: a = 32'h0;
        endcase
        case (cur.srcb)
            2'd0: b = m_regs[m_ir[20:16]];
            2'd1: b = 32'd4;
            2'd2: b = sx;
            default: b = sx * 4;
        endcase
        alu_ref(cur.op, a, b, m_ir[10:6], r, v);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_pc = 0; m_ir = 0; m_mdr = 0; m_aout = 0; m_aout2 = 0; m_dtc = 0;
    endfunction

    // One rising edge worth of architectural effect for the control word in cur.
    function automatic void model_step();
        logic [31:0] r, npc, wd;
        logic [4:0]  wa;
        logic        v;
        model_eval(r, v);
        case (cur.regdst)
            2'd0: wa = m_ir[20:16];
            2'd1: wa = m_ir[15:11];
            2'd2: wa = 5'd31;
            default: wa = 5'd0;
        endcase
        case (cur.m2r)
            2'd0: wd = m_aout;
            2'd1: wd = m_mdr;
            2'd2: wd = {m_ir[15:0], 16'h0000};
            default: wd = m_pc;
        endcase
        npc = m_pc;
        if (cur.pcw || (cur.pcwc && ((r == 0) == cur.beq))) begin
            if (cur.pcsrc == 2'd0) begin
                if (cur.mio) npc = r;
            end else if (cur.pcsrc == 2'd2) begin
                npc = {m_pc[31:28], m_ir[25:0], 2'b00};
            end else begin
                npc = m_aout;
            end
        end
        if (cur.rw && wa != 0) m_regs[wa] = wd;
        m_aout2 = m_aout;
        m_aout  = r;
        m_dtc   = cur.din;
        if (cur.mio) m_mdr = cur.din;
        if (cur.irw && cur.mio) m_ir = cur.din;
        m_pc = npc;
    endfunction

    task automatic apply_stimulus(input ctrl_t c);
        cur = c;
        bus.MIO_ready     = c.mio;
        bus.IorD          = c.iord;
        bus.IRWrite       = c.irw;
        bus.RegWrite      = c.rw;
        bus.PCWrite       = c.pcw;
        bus.PCWriteCond   = c.pcwc;
        bus.Beq           = c.beq;
        bus.data2Mem      = c.d2m;
        bus.RegDst        = c.regdst;
        bus.ALUSrcA       = c.srca;
        bus.ALUSrcB       = c.srcb;
        bus.PCSource      = c.pcsrc;
        bus.MemtoReg      = c.m2r;
        bus.ALU_operation = c.op;
        bus.data2CPU      = c.din;
    endtask

    task automatic push_expected();
        exp_t        e;
        logic [31:0] r;
        logic        v;
        model_eval(r, v);
        e.pc    = m_pc;
        e.ir    = m_ir;
        e.maddr = cur.iord ? m_pc : m_aout;
        e.dout  = cur.d2m ? m_aout2 : m_regs[m_ir[20:16]];
        e.z     = (r == 0);
        e.v     = v;
        exp_q.push_back(e);
    endtask

    task automatic drive_cycle(input ctrl_t c);
        @(posedge clk);
        model_step();
        #1;
        apply_stimulus(c);
        push_expected();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("PC_Current", bus.PC_Current, e.pc);
            check_output("Inst_R", bus.Inst_R, e.ir);
            check_output("M_addr", bus.M_addr, e.maddr);
            check_output("data_out", bus.data_out, e.dout);
            check_output("zero", {31'd0, bus.zero}, {31'd0, e.z});
            check_output("overflow", {31'd0, bus.overflow}, {31'd0, e.v});
        end
    end

    initial begin
        ctrl_t       c;
        ctrl_t       idle;
        logic [63:0] rnd;
        idle = '0;

        reset = 1'b0;
        apply_stimulus(idle);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_pc", bus.PC_Current, 32'h0);
        check_output("reset_ir", bus.Inst_R, 32'h0);
        c = idle; c.iord = 1'b1;
        apply_stimulus(c);
        reset = 1'b1;
        push_expected();
        #1;
        check_output("reset_maddr", bus.M_addr, 32'h0);
        check_output("reset_zero", {31'd0, bus.zero}, 32'd1);

        // Fetch with and without memory ready.
        c = idle; c.iord = 1; c.irw = 1; c.mio = 1; c.srca = 2'd1; c.srcb = 2'd1;
        c.op = 4'd2; c.pcw = 1; c.pcsrc = 2'd0; c.din = 32'h2001_0005;
        drive_cycle(c);
        drive_cycle(idle);
        check_output("fetch_ir", bus.Inst_R, 32'h2001_0005);
        check_output("fetch_pc", bus.PC_Current, 32'd4);
        c.mio = 0; c.din = 32'hDEAD_BEEF;
        drive_cycle(c);
        drive_cycle(idle);
        check_output("fetch_hold_pc", bus.PC_Current, 32'd4);
        check_output("fetch_hold_ir", bus.Inst_R, 32'h2001_0005);

        // addi $1,$0,5 then attempted write to $0.
        c = idle; c.srcb = 2'd2; c.op = 4'd2;
        drive_cycle(c);
        c.rw = 1;
        drive_cycle(c);
        drive_cycle(idle);
        #1;
        check_output("addi_r1", bus.data_out, 32'd5);
        c = idle; c.rw = 1; c.regdst = 2'd3; c.m2r = 2'd1;
        drive_cycle(c);
        c = idle; c.srcb = 2'd1; c.op = 4'd1;
        drive_cycle(c);
        drive_cycle(idle);
        #1;
        check_output("r0_stays_zero", bus.M_addr, 32'd4);

        // Branch: $1 = $2 = 7, ALU_Out primed with 14.
        c = idle; c.irw = 1; c.mio = 1; c.din = 32'h0022_0800;
        drive_cycle(c);
        c = idle; c.mio = 1; c.din = 32'd7;
        drive_cycle(c);
        c = idle; c.rw = 1; c.m2r = 2'd1;
        drive_cycle(c);
        c.regdst = 2'd1;
        drive_cycle(c);
        c = idle; c.op = 4'd2;
        drive_cycle(c);
        c = idle; c.op = 4'd6; c.pcwc = 1; c.beq = 1; c.pcsrc = 2'd1;
        drive_cycle(c);
        #1;
        check_output("beq_zero", {31'd0, bus.zero}, 32'd1);
        c.beq = 0;
        drive_cycle(c);
        check_output("beq_taken_pc", bus.PC_Current, 32'd14);
        drive_cycle(idle);
        check_output("bne_not_taken_pc", bus.PC_Current, 32'd14);

        // Overflow on 0x7FFFFFFF + 1, none on 0 - 1.
        c = idle; c.irw = 1; c.mio = 1; c.din = 32'h0000_0001;
        drive_cycle(c);
        c = idle; c.din = 32'h7FFF_FFFF;
        drive_cycle(c);
        c = idle; c.srca = 2'd2; c.srcb = 2'd2; c.op = 4'd2;
        drive_cycle(c);
        #1;
        check_output("add_ovf", {31'd0, bus.overflow}, 32'd1);
        c = idle; c.srca = 2'd3; c.srcb = 2'd2; c.op = 4'd6;
        drive_cycle(c);
        #1;
        check_output("sub_no_ovf", {31'd0, bus.overflow}, 32'd0);
        check_output("add_result", bus.M_addr, 32'h8000_0000);
        drive_cycle(idle);
        check_output("sub_result", bus.M_addr, 32'hFFFF_FFFF);

        // Jump from PC 0x10000000 with target field 0x10.
        c = idle; c.din = 32'h1000_0000;
        drive_cycle(c);
        c = idle; c.srca = 2'd2; c.op = 4'd1; c.irw = 1; c.mio = 1; c.din = 32'h0800_0010;
        drive_cycle(c);
        c = idle; c.pcw = 1; c.pcsrc = 2'd1;
        drive_cycle(c);
        c.pcsrc = 2'd2;
        drive_cycle(c);
        check_output("jump_base_pc", bus.PC_Current, 32'h1000_0000);
        drive_cycle(idle);
        check_output("jump_pc", bus.PC_Current, 32'h1000_0040);

        for (int i = 0; i < 400; i++) begin
            rnd = {$urandom(), $urandom()};
            c = rnd[$bits(ctrl_t)-1:0];
            drive_cycle(c);
        end

        // Asynchronous reset between edges.
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_output("async_pc", bus.PC_Current, 32'h0);
        check_output("async_ir", bus.Inst_R, 32'h0);
        check_output("async_dout", bus.data_out, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        apply_stimulus(idle);
        push_expected();

        for (int i = 0; i < 60; i++) begin
            rnd = {$urandom(), $urandom()};
            c = rnd[$bits(ctrl_t)-1:0];
            drive_cycle(c);
        end

        @(negedge clk);
        #1;
        check_output("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
